// File: rtl/chip8_pkg.sv
// Shared CHIP-8 definitions: opcode classes produced by the decoder and the
// sequencer FSM state encoding.
package chip8_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH_HI,
        ST_FETCH_LO,
        ST_LATCH,
        ST_DECODE,
        ST_EXEC,
        ST_WAIT,
        ST_FAULT
    } seq_state_t;

    localparam logic [5:0] OP_SYS          = 6'd0;
    localparam logic [5:0] OP_DISP_CLR     = 6'd1;
    localparam logic [5:0] OP_RET          = 6'd2;
    localparam logic [5:0] OP_JMP          = 6'd3;
    localparam logic [5:0] OP_CALL         = 6'd4;
    localparam logic [5:0] OP_SE_VX_BYTE   = 6'd5;
    localparam logic [5:0] OP_SNE_VX_BYTE  = 6'd6;
    localparam logic [5:0] OP_SE_VX_VY     = 6'd7;
    localparam logic [5:0] OP_LD_VX_BYTE   = 6'd8;
    localparam logic [5:0] OP_ADD_VX_BYTE  = 6'd9;
    localparam logic [5:0] OP_LD_VX_VY     = 6'd10;
    localparam logic [5:0] OP_OR_VX_VY     = 6'd11;
    localparam logic [5:0] OP_AND_VX_VY    = 6'd12;
    localparam logic [5:0] OP_XOR_VX_VY    = 6'd13;
    localparam logic [5:0] OP_ADD_VX_VY    = 6'd14;
    localparam logic [5:0] OP_SUB_VX_VY    = 6'd15;
    localparam logic [5:0] OP_SHR_VX       = 6'd16;
    localparam logic [5:0] OP_SUBN_VX_VY   = 6'd17;
    localparam logic [5:0] OP_SHL_VX       = 6'd18;
    localparam logic [5:0] OP_SNE_VX_VY    = 6'd19;
    localparam logic [5:0] OP_LD_I_ADDR    = 6'd20;
    localparam logic [5:0] OP_JMP_V0_ADDR  = 6'd21;
    localparam logic [5:0] OP_RND_VX_BYTE  = 6'd22;
    localparam logic [5:0] OP_DRW          = 6'd23;
    localparam logic [5:0] OP_SKP_VX       = 6'd24;
    localparam logic [5:0] OP_SKNP_VX      = 6'd25;
    localparam logic [5:0] OP_LD_VX_DT     = 6'd26;
    localparam logic [5:0] OP_LD_VX_K      = 6'd27;
    localparam logic [5:0] OP_LD_DT_VX     = 6'd28;
    localparam logic [5:0] OP_LD_ST_VX     = 6'd29;
    localparam logic [5:0] OP_ADD_I_VX     = 6'd30;
    localparam logic [5:0] OP_LD_F_VX      = 6'd31;
    localparam logic [5:0] OP_LD_B_VX      = 6'd32;
    localparam logic [5:0] OP_STORE_REG_VX = 6'd33;
    localparam logic [5:0] OP_READ_REG_VX  = 6'd34;

    // Classes the sequencer resolves itself; everything else goes to the execution units.
    function automatic logic is_internal(input logic [5:0] cls);
        return (cls == OP_SYS) || (cls == OP_RET) || (cls == OP_JMP) || (cls == OP_CALL);
    endfunction

endpackage

// File: rtl/call_stack.sv
// Return-address stack. With CPU_STACK_CHECK_EN the pointer saturates at DEPTH
// (caller must honour full/empty); otherwise it wraps modulo DEPTH.
module call_stack
    import chip8_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [11:0]                push_data,
    output logic [11:0]                top_data,
    output logic [$clog2(DEPTH):0]     sp,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] ONE = {{AW{1'b0}}, 1'b1};

    logic [11:0]   mem [DEPTH];
    logic [AW:0]   sp_up;
    logic [AW:0]   sp_down;
    logic [AW-1:0] top_idx;

`ifdef CPU_STACK_CHECK_EN
    assign sp_up   = sp + ONE;
    assign sp_down = sp - ONE;
`else
    assign sp_up   = {1'b0, sp[AW-1:0] + ONE[AW-1:0]};
    assign sp_down = {1'b0, sp[AW-1:0] - ONE[AW-1:0]};
`endif

    assign top_idx  = sp[AW-1:0] - ONE[AW-1:0];
    assign top_data = mem[top_idx];
    // sp never exceeds DEPTH, so the extra bit alone marks a full stack.
    assign full     = sp[AW];
    assign empty    = (sp == '0);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[sp[AW-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp <= '0;
        end else if (push) begin
            sp <= sp_up;
        end else if (pop) begin
            sp <= sp_down;
        end
    end

endmodule

// File: rtl/cpu_sequencer.sv
// CHIP-8 fetch/decode/dispatch sequencer with return stack.
// Optional stack over/underflow trapping via macro CPU_STACK_CHECK_EN.
module cpu_sequencer
    import chip8_pkg::*;
#(
    parameter logic [11:0] PC_RESET    = 12'h200,
    parameter int          STACK_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    output logic        mem_rd,
    output logic [11:0] mem_addr,
    input  logic [7:0]  mem_rdata,
    output logic [15:0] instruction,
    input  logic [5:0]  decode,
    input  logic [11:0] addr_in,
    output logic        exec_start,
    input  logic        exec_done,
    input  logic        exec_skip,
    input  logic        exec_load,
    input  logic [11:0] exec_pc,
    output logic [11:0] pc,
    output logic        busy,
    output logic        fault
);

    localparam int AW = $clog2(STACK_DEPTH);

    seq_state_t  state_reg;
    logic [7:0]  hi_reg;
    logic        fault_reg;
    logic        push;
    logic        pop;
    logic [11:0] top_data;
    logic [AW:0] sp;
    logic        full;
    logic        empty;
    logic        unused_stack;

`ifdef CPU_STACK_CHECK_EN
    assign push  = (state_reg == ST_EXEC) && (decode == OP_CALL) && !full;
    assign pop   = (state_reg == ST_EXEC) && (decode == OP_RET) && !empty;
    assign fault = fault_reg;
`else
    assign push  = (state_reg == ST_EXEC) && (decode == OP_CALL);
    assign pop   = (state_reg == ST_EXEC) && (decode == OP_RET);
    assign fault = 1'b0;
`endif

    // Decoded from the state register so the pulse lands in EXEC itself,
    // letting exec_done arrive in the very next cycle.
    assign exec_start   = (state_reg == ST_EXEC) && !is_internal(decode);
    assign busy         = (state_reg != ST_IDLE) && (state_reg != ST_FAULT);
    assign unused_stack = &{1'b0, sp, full, empty, fault_reg};

    call_stack #(.DEPTH(STACK_DEPTH)) u_call_stack (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .push_data (pc),
        .top_data  (top_data),
        .sp        (sp),
        .full      (full),
        .empty     (empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            pc          <= PC_RESET;
            instruction <= 16'h0000;
            hi_reg      <= 8'h00;
            mem_rd      <= 1'b0;
            mem_addr    <= 12'h000;
            fault_reg   <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (run) begin
                        mem_rd    <= 1'b1;
                        mem_addr  <= pc;
                        state_reg <= ST_FETCH_HI;
                    end
                end
                ST_FETCH_HI: begin
                    mem_addr  <= pc + 12'd1;
                    state_reg <= ST_FETCH_LO;
                end
                ST_FETCH_LO: begin
                    hi_reg    <= mem_rdata;
                    mem_rd    <= 1'b0;
                    state_reg <= ST_LATCH;
                end
                ST_LATCH: begin
                    instruction <= {hi_reg, mem_rdata};
                    pc          <= pc + 12'd2;
                    state_reg   <= ST_DECODE;
                end
                ST_DECODE: begin
                    state_reg <= ST_EXEC;
                end
                ST_EXEC: begin
                    case (decode)
                        OP_JMP: begin
                            pc        <= addr_in;
                            state_reg <= ST_IDLE;
                        end
                        OP_CALL: begin
`ifdef CPU_STACK_CHECK_EN
                            if (full) begin
                                fault_reg <= 1'b1;
                                state_reg <= ST_FAULT;
                            end else
`endif
                            begin
                                pc        <= addr_in;
                                state_reg <= ST_IDLE;
                            end
                        end
                        OP_RET: begin
`ifdef CPU_STACK_CHECK_EN
                            if (empty) begin
                                fault_reg <= 1'b1;
                                state_reg <= ST_FAULT;
                            end else
`endif
                            begin
                                pc        <= top_data;
                                state_reg <= ST_IDLE;
                            end
                        end
                        OP_SYS: begin
                            state_reg <= ST_IDLE;
                        end
                        default: begin
                            state_reg <= ST_WAIT;
                        end
                    endcase
                end
                ST_WAIT: begin
                    if (exec_done) begin
                        if (exec_load) begin
                            pc <= exec_pc;
                        end else if (exec_skip) begin
                            pc <= pc + 12'd2;
                        end
                        state_reg <= ST_IDLE;
                    end
                end
                ST_FAULT: begin
                    state_reg <= ST_FAULT;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: models program RAM, decoder and an
// execution unit, and predicts pc/latency from instruction-level semantics.
module tb_cpu_sequencer;
    import chip8_pkg::*;

    localparam int          D   = 16;
    localparam logic [11:0] PCR = 12'h200;

    logic        clk = 1'b0;
    logic        rst;
    logic        run;
    logic        mem_rd;
    logic [11:0] mem_addr;
    logic [7:0]  mem_rdata = 8'h00;
    logic [15:0] instruction;
    logic [5:0]  decode = 6'd0;
    logic [11:0] addr_in = 12'h000;
    logic        exec_start;
    logic        exec_done;
    logic        exec_skip;
    logic        exec_load;
    logic [11:0] exec_pc;
    logic [11:0] pc;
    logic        busy;
    logic        fault;

    logic        resp_done = 1'b0;
    logic        spur_done = 1'b0;
    int          resp_delay = 1;
    int          start_count = 0;
    int          total = 0;
    int          bad = 0;

    logic [7:0]  ram [4096];
    logic [11:0] m_pc;
    logic [11:0] m_stack [D];
    int          m_sp;

    assign exec_done = resp_done | spur_done;

    cpu_sequencer #(.PC_RESET(PCR), .STACK_DEPTH(D)) dut (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .mem_rd      (mem_rd),
        .mem_addr    (mem_addr),
        .mem_rdata   (mem_rdata),
        .instruction (instruction),
        .decode      (decode),
        .addr_in     (addr_in),
        .exec_start  (exec_start),
        .exec_done   (exec_done),
        .exec_skip   (exec_skip),
        .exec_load   (exec_load),
        .exec_pc     (exec_pc),
        .pc          (pc),
        .busy        (busy),
        .fault       (fault)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_rd) mem_rdata <= ram[mem_addr];
    end

    function automatic logic [5:0] classify(input logic [15:0] op);
        case (op[15:12])
            4'h0:    classify = (op == 16'h00E0) ? OP_DISP_CLR : (op == 16'h00EE) ? OP_RET : OP_SYS;
            4'h1:    classify = OP_JMP;
            4'h2:    classify = OP_CALL;
            4'h3:    classify = OP_SE_VX_BYTE;
            4'h4:    classify = OP_SNE_VX_BYTE;
            4'h5:    classify = OP_SE_VX_VY;
            4'h6:    classify = OP_LD_VX_BYTE;
            4'h7:    classify = OP_ADD_VX_BYTE;
            4'h8:    classify = OP_LD_VX_VY;
            4'h9:    classify = OP_SNE_VX_VY;
            4'hA:    classify = OP_LD_I_ADDR;
            4'hB:    classify = OP_JMP_V0_ADDR;
            4'hC:    classify = OP_RND_VX_BYTE;
            4'hD:    classify = OP_DRW;
            4'hE:    classify = OP_SKP_VX;
            default: classify = OP_LD_VX_DT;
        endcase
    endfunction

    always @(posedge clk) begin
        decode  <= classify(instruction);
        addr_in <= instruction[11:0];
    end

    always @(negedge clk) begin
        if (exec_start === 1'b1) start_count++;
    end

    // Execution unit: completes resp_delay cycles after seeing exec_start.
    initial begin
        forever begin
            @(negedge clk);
            if (exec_start === 1'b1) begin
                repeat (resp_delay - 1) @(posedge clk);
                @(posedge clk);
                #1 resp_done = 1'b1;
                @(posedge clk);
                #1 resp_done = 1'b0;
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        run = 1'b0;
        repeat (2) @(negedge clk);
        rst  = 1'b0;
        m_pc = PCR;
        m_sp = 0;
    endtask

    task automatic run_one(output int cyc);
        logic [11:0] a1;
        int g;
        a1  = m_pc + 12'd1;
        cyc = 0;
        @(negedge clk) run = 1'b1;
        g = 0;
        do begin @(negedge clk); g++; end while (mem_rd !== 1'b1 && g < 4);
        run = 1'b0;
        total++;
        if (mem_rd !== 1'b1 || mem_addr !== m_pc)
            $display("FAIL fetch_hi: rd=%b addr=%h want rd=1 addr=%h", mem_rd, mem_addr, m_pc);
        if (mem_rd !== 1'b1 || mem_addr !== m_pc) bad++;
        @(negedge clk);
        cyc = 1;
        total++;
        if (mem_rd !== 1'b1 || mem_addr !== a1) begin
            bad++;
            $display("FAIL fetch_lo: rd=%b addr=%h want rd=1 addr=%h", mem_rd, mem_addr, a1);
        end
        do begin @(negedge clk); cyc++; end while (busy !== 1'b0 && cyc < 60);
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL idle_timeout: busy=%b after %0d cycles want 0", busy, cyc);
        end
    endtask

    task automatic do_instr(input logic [15:0] op, input int dly, input bit skip,
                            input bit load, input logic [11:0] epc);
        logic [11:0] a1, npc;
        int cyc, s0, exp_cyc, exp_st;
        a1 = m_pc + 12'd1;
        ram[m_pc] = op[15:8];
        ram[a1]   = op[7:0];
        resp_delay = dly;
        exec_skip  = skip;
        exec_load  = load;
        exec_pc    = epc;
        s0 = start_count;
        run_one(cyc);
        npc = m_pc + 12'd2;
        exp_cyc = 5;
        exp_st  = 0;
        if (op[15:12] == 4'h1) begin
            npc = op[11:0];
        end else if (op[15:12] == 4'h2) begin
            m_stack[m_sp % D] = npc;
            m_sp++;
            npc = op[11:0];
        end else if (op == 16'h00EE) begin
            m_sp--;
            npc = m_stack[m_sp % D];
        end else if (op[15:12] == 4'h0 && op != 16'h00E0) begin
            npc = m_pc + 12'd2;
        end else begin
            exp_cyc = 5 + dly;
            exp_st  = 1;
            if (load) npc = epc;
            else if (skip) npc = npc + 12'd2;
        end
        $display("op %h at %h -> pc %h cycles %0d", op, m_pc, pc, cyc);
        total++;
        if (pc !== npc) begin
            bad++;
            $display("FAIL pc op=%h: got %h want %h", op, pc, npc);
        end
        total++;
        if (cyc !== exp_cyc) begin
            bad++;
            $display("FAIL latency op=%h: got %0d want %0d", op, cyc, exp_cyc);
        end
        total++;
        if (instruction !== op) begin
            bad++;
            $display("FAIL instruction: got %h want %h", instruction, op);
        end
        total++;
        if (start_count - s0 !== exp_st) begin
            bad++;
            $display("FAIL exec_start op=%h: got %0d pulses want %0d", op, start_count - s0, exp_st);
        end
        total++;
        if (fault !== 1'b0) begin
            bad++;
            $display("FAIL fault op=%h: got %b want 0", op, fault);
        end
        m_pc = npc;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (pc !== PCR || busy !== 1'b0 || mem_rd !== 1'b0 || mem_addr !== 12'h000 ||
            instruction !== 16'h0000 || exec_start !== 1'b0 || fault !== 1'b0) begin
            bad++;
            $display("FAIL reset: pc=%h busy=%b rd=%b addr=%h ins=%h start=%b fault=%b want pc=%h rest 0",
                     pc, busy, mem_rd, mem_addr, instruction, exec_start, fault, PCR);
        end
    endtask

    task automatic test_fetch_jmp();
        do_reset();
        do_instr(16'h1234, 1, 0, 0, 12'h000);
        repeat (3) @(negedge clk);
        total++;
        if (busy !== 1'b0 || mem_rd !== 1'b0 || pc !== 12'h234) begin
            bad++;
            $display("FAIL idle_hold: busy=%b rd=%b pc=%h want 0 0 234", busy, mem_rd, pc);
        end
    endtask

    task automatic test_call_ret();
        do_reset();
        do_instr(16'h2400, 1, 0, 0, 12'h000);
        do_instr(16'h00EE, 1, 0, 0, 12'h000);
    endtask

    task automatic test_dispatch();
        do_reset();
        do_instr(16'h3412, 3, 1, 0, 12'h000);
        do_reset();
        do_instr(16'h3412, 3, 0, 0, 12'h000);
        do_instr(16'hB123, 2, 1, 1, 12'h3A5);
        do_instr(16'h00E0, 1, 1, 0, 12'h000);
        do_instr(16'h8120, 1, 0, 1, 12'h111);
    endtask

    task automatic test_spurious_done();
        do_reset();
        spur_done = 1'b1;
        do_instr(16'h1456, 1, 1, 1, 12'h777);
        do_instr(16'h0123, 1, 1, 1, 12'h777);
        spur_done = 1'b0;
    endtask

    task automatic test_pc_wrap();
        do_reset();
        do_instr(16'h1FFE, 1, 0, 0, 12'h000);
        do_instr(16'h0000, 1, 0, 0, 12'h000);
        do_instr(16'h1FFF, 1, 0, 0, 12'h000);
        do_instr(16'h13A0, 1, 0, 0, 12'h000);
    endtask

    task automatic test_random();
        logic [15:0] op;
        int kind;
        do_reset();
        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 7);
            if (kind == 1 && m_sp >= D) kind = 0;
            if (kind == 2 && m_sp == 0) kind = 1;
            case (kind)
                0:       op = {4'h1, 12'($urandom_range(0, 4095))};
                1:       op = {4'h2, 12'($urandom_range(0, 4095))};
                2:       op = 16'h00EE;
                3:       op = {4'h0, 12'($urandom_range(12'h100, 12'hDFF))};
                4:       op = 16'h00E0;
                default: op = {4'($urandom_range(3, 15)), 12'($urandom_range(0, 4095))};
            endcase
            do_instr(op, $urandom_range(1, 4), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), 12'($urandom_range(0, 4095)));
        end
    endtask

    task automatic test_stack_limit();
        int cyc;
        do_reset();
        for (int i = 0; i < D; i++) do_instr({4'h2, 12'h300 + 12'(i * 16)}, 1, 0, 0, 12'h000);
`ifdef CPU_STACK_CHECK_EN
        ram[m_pc] = 8'h2A;
        ram[m_pc + 12'd1] = 8'hBC;
        run_one(cyc);
        total++;
        if (fault !== 1'b1 || busy !== 1'b0 || pc !== m_pc + 12'd2) begin
            bad++;
            $display("FAIL overflow: fault=%b busy=%b pc=%h want 1 0 %h", fault, busy, pc, m_pc + 12'd2);
        end
        @(negedge clk) run = 1'b1;
        repeat (4) @(negedge clk);
        run = 1'b0;
        total++;
        if (mem_rd !== 1'b0 || busy !== 1'b0 || fault !== 1'b1) begin
            bad++;
            $display("FAIL fault_hold: rd=%b busy=%b fault=%b want 0 0 1", mem_rd, busy, fault);
        end
        do_reset();
        ram[PCR] = 8'h00;
        ram[PCR + 12'd1] = 8'hEE;
        run_one(cyc);
        total++;
        if (fault !== 1'b1 || pc !== PCR + 12'd2) begin
            bad++;
            $display("FAIL underflow: fault=%b pc=%h want 1 %h", fault, pc, PCR + 12'd2);
        end
        do_reset();
        total++;
        if (fault !== 1'b0) begin
            bad++;
            $display("FAIL fault_clear: got %b want 0", fault);
        end
`else
        do_instr(16'h2ABC, 1, 0, 0, 12'h000);
        do_instr(16'h00EE, 1, 0, 0, 12'h000);
        do_instr(16'h00EE, 1, 0, 0, 12'h000);
`endif
    endtask

    task automatic test_reset_mid_fetch();
        do_reset();
        ram[PCR] = 8'h12;
        ram[PCR + 12'd1] = 8'h34;
        @(negedge clk) run = 1'b1;
        @(negedge clk) run = 1'b0;
        #2 rst = 1'b1;
        #1;
        total++;
        if (mem_rd !== 1'b0 || mem_addr !== 12'h000 || busy !== 1'b0 || pc !== PCR) begin
            bad++;
            $display("FAIL reset_fetch: rd=%b addr=%h busy=%b pc=%h want 0 000 0 %h",
                     mem_rd, mem_addr, busy, pc, PCR);
        end
        @(negedge clk) rst = 1'b0;
    endtask

    task automatic test_reset_in_wait();
        int g, s0;
        do_reset();
        ram[PCR] = 8'h51;
        ram[PCR + 12'd1] = 8'h20;
        resp_delay = 12;
        exec_load  = 1'b1;
        exec_pc    = 12'h555;
        @(negedge clk) run = 1'b1;
        g = 0;
        do begin @(negedge clk); g++; end while (exec_start !== 1'b1 && g < 10);
        run = 1'b0;
        total++;
        if (exec_start !== 1'b1) begin
            bad++;
            $display("FAIL dispatch_wait: exec_start=%b want 1", exec_start);
        end
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        total++;
        if (pc !== PCR || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_wait: pc=%h busy=%b want %h 0", pc, busy, PCR);
        end
        @(negedge clk) rst = 1'b0;
        s0 = start_count;
        repeat (16) @(negedge clk);
        total++;
        if (pc !== PCR || busy !== 1'b0 || start_count !== s0 || mem_rd !== 1'b0) begin
            bad++;
            $display("FAIL late_done: pc=%h busy=%b starts=%0d rd=%b want %h 0 0 0",
                     pc, busy, start_count - s0, mem_rd, PCR);
        end
    endtask

    initial begin
        rst       = 1'b1;
        run       = 1'b0;
        exec_skip = 1'b0;
        exec_load = 1'b0;
        exec_pc   = 12'h000;
        for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
        for (int i = 0; i < D; i++) m_stack[i] = 12'h000;
        test_reset();
        test_fetch_jmp();
        test_call_ret();
        test_dispatch();
        test_spurious_done();
        test_pc_wrap();
        test_random();
        test_stack_limit();
        test_reset_mid_fetch();
        test_reset_in_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
